// File: rtl/snake_head_stepper.sv
`default_nettype none
// ============================================================================
// snake_head_stepper: snake head position stepper for a GRID_W x GRID_H
// playfield, with direction buffering, run control, wrap/wall edges and a
// move counter.
// Revision: 1.0
// ============================================================================
module snake_head_stepper #(
  parameter int          GRID_W    = 12,
  parameter int          GRID_H    = 9,
  parameter int          CW        = 4,
  parameter bit          WRAP      = 1'b1,
  parameter int          START_X   = 0,
  parameter int          START_Y   = 0,
  parameter logic [1:0]  START_DIR = 2'b00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          tick,
  input  logic          dir_valid,
  input  logic [1:0]    dir_in,
  output logic [CW-1:0] xcord,
  output logic [CW-1:0] ycord,
  output logic [1:0]    cur_dir,
  output logic          running,
  output logic          moved,
  output logic          dir_rejected,
  output logic          wall_hit,
  output logic [15:0]   move_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_X_MAX   = CW'(GRID_W - 1);
  localparam logic [CW-1:0] C_Y_MAX   = CW'(GRID_H - 1);
  localparam logic [CW-1:0] C_START_X = CW'(START_X);
  localparam logic [CW-1:0] C_START_Y = CW'(START_Y);

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [1:0]    cur_dir_q, cur_dir_d;
  logic [1:0]    pend_dir_q, pend_dir_d;
  logic          running_q, running_d;
  logic          moved_q, moved_d;
  logic          rejected_q, rejected_d;
  logic          wall_hit_q, wall_hit_d;
  logic [15:0]   count_q, count_d;

  logic          step;
  logic [1:0]    ref_dir;
  logic          reversal;
  logic          at_edge;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;

  // Next coordinate for the pending direction, including edge detection.
  always_comb begin
    x_next  = x_q;
    y_next  = y_q;
    at_edge = 1'b0;
    case (pend_dir_q)
      2'b00: begin
        at_edge = (y_q == C_Y_MAX);
        y_next  = at_edge ? '0 : y_q + 1'b1;
      end
      2'b01: begin
        at_edge = (y_q == '0);
        y_next  = at_edge ? C_Y_MAX : y_q - 1'b1;
      end
      2'b10: begin
        at_edge = (x_q == C_X_MAX);
        x_next  = at_edge ? '0 : x_q + 1'b1;
      end
      default: begin
        at_edge = (x_q == '0);
        x_next  = at_edge ? C_X_MAX : x_q - 1'b1;
      end
    endcase
  end

  // A step in flight executes pend_dir, so reversal is judged against it.
  always_comb begin
    step     = (state_q == ST_RUN) && tick;
    ref_dir  = step ? pend_dir_q : cur_dir_q;
    reversal = (dir_in[1] == ref_dir[1]) && (dir_in[0] != ref_dir[0]);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    moved_d    = 1'b0;
    rejected_d = 1'b0;
    wall_hit_d = wall_hit_q;
    count_d    = count_q;

    if (dir_valid && (state_q != ST_DEAD)) begin
      if (reversal) begin
        rejected_d = 1'b1;
      end else begin
        pend_dir_d = dir_in;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step) begin
          cur_dir_d = pend_dir_q;
          if (at_edge && !WRAP) begin
            state_d    = ST_DEAD;
            wall_hit_d = 1'b1;
          end else begin
            x_d     = x_next;
            y_d     = y_next;
            moved_d = 1'b1;
            if (count_q != 16'hFFFF) begin
              count_d = count_q + 16'd1;
            end
          end
        end
      end
      default: begin
        state_d = ST_DEAD;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= C_START_X;
      y_q        <= C_START_Y;
      cur_dir_q  <= START_DIR;
      pend_dir_q <= START_DIR;
      running_q  <= 1'b0;
      moved_q    <= 1'b0;
      rejected_q <= 1'b0;
      wall_hit_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      running_q  <= running_d;
      moved_q    <= moved_d;
      rejected_q <= rejected_d;
      wall_hit_q <= wall_hit_d;
      count_q    <= count_d;
    end
  end

  assign xcord        = x_q;
  assign ycord        = y_q;
  assign cur_dir      = cur_dir_q;
  assign running      = running_q;
  assign moved        = moved_q;
  assign dir_rejected = rejected_q;
  assign wall_hit     = wall_hit_q;
  assign move_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_head_stepper.sv
`default_nettype none
// ============================================================================
// tb_snake_head_stepper: directed bench for a wrap-mode and a wall-mode
// instance driven from shared inputs.
// Revision: 1.0
// ============================================================================
module tb_snake_head_stepper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic        dir_valid = 1'b0;
  logic [1:0]  dir_in = 2'b00;

  logic [3:0]  wx, wy, lx, ly;
  logic [1:0]  wdir, ldir;
  logic        wrun, lrun, wmov, lmov, wrej, lrej, whit, lhit;
  logic [15:0] wcnt, lcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snake_head_stepper #(.GRID_W(12), .GRID_H(9), .CW(4), .WRAP(1'b1),
                       .START_X(0), .START_Y(0), .START_DIR(2'b00)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .dir_valid(dir_valid), .dir_in(dir_in),
    .xcord(wx), .ycord(wy), .cur_dir(wdir), .running(wrun), .moved(wmov),
    .dir_rejected(wrej), .wall_hit(whit), .move_count(wcnt)
  );

  snake_head_stepper #(.GRID_W(12), .GRID_H(9), .CW(4), .WRAP(1'b0),
                       .START_X(0), .START_Y(0), .START_DIR(2'b00)) u_wall (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .dir_valid(dir_valid), .dir_in(dir_in),
    .xcord(lx), .ycord(ly), .cur_dir(ldir), .running(lrun), .moved(lmov),
    .dir_rejected(lrej), .wall_hit(lhit), .move_count(lcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs set beforehand are sampled on this edge; outputs read #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_dir(input logic [1:0] d);
    dir_valid = 1'b1;
    dir_in    = d;
    cyc();
    dir_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic chk_w(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(wx), 32'(x));
    chk({tag, "_y"}, 32'(wy), 32'(y));
  endtask

  initial begin
    // Reset state
    do_reset();
    cyc();
    chk_w("rst", 0, 0);
    chk("rst_dir", 32'(wdir), 0);
    chk("rst_run", 32'(wrun), 0);
    chk("rst_mov", 32'(wmov), 0);
    chk("rst_rej", 32'(wrej), 0);
    chk("rst_hit", 32'(whit), 0);
    chk("rst_cnt", 32'(wcnt), 0);

    // tick in IDLE does nothing
    do_tick();
    chk_w("idle_tick", 0, 0);
    chk("idle_tick_mov", 32'(wmov), 0);
    chk("idle_tick_cnt", 32'(wcnt), 0);

    do_start();
    chk("start_run", 32'(wrun), 1);

    // Nine y+1 steps wrap back to row 0
    for (int i = 1; i <= 9; i++) begin
      do_tick();
      chk_w($sformatf("yup%0d", i), 0, i % 9);
      chk($sformatf("yup%0d_mov", i), 32'(wmov), 1);
    end
    chk("yup_cnt", 32'(wcnt), 9);
    cyc();
    chk("mov_pulse_end", 32'(wmov), 0);

    for (int i = 0; i < 3; i++) do_tick();
    chk_w("to_0_3", 0, 3);

    // x-1 from column 0 wraps to 11
    do_dir(2'b11);
    chk("acc_11_rej", 32'(wrej), 0);
    do_tick();
    chk_w("xwrap", 11, 3);
    chk("xwrap_dir", 32'(wdir), 3);
    chk("xwrap_cnt", 32'(wcnt), 13);

    do_dir(2'b00);
    do_tick();
    chk_w("to_11_4", 11, 4);
    do_dir(2'b10);
    do_tick();
    chk_w("xwrap_hi", 0, 4);
    chk("cur10", 32'(wdir), 2);

    // Reversal rejected, then a legal turn accepted
    do_dir(2'b11);
    chk("rev_rej", 32'(wrej), 1);
    cyc();
    chk("rev_rej_end", 32'(wrej), 0);
    do_tick();
    chk_w("after_rev", 1, 4);
    do_dir(2'b00);
    chk("turn_rej", 32'(wrej), 0);
    do_tick();
    chk_w("after_turn", 1, 5);
    chk("turn_cnt", 32'(wcnt), 17);

    // Reach (2,2) with pend_dir = 10
    do_dir(2'b10);
    do_tick();
    chk_w("to_2_5", 2, 5);
    do_dir(2'b01);
    for (int i = 0; i < 3; i++) do_tick();
    chk_w("to_2_2", 2, 2);
    do_dir(2'b10);

    // tick and dir_valid together: step uses old pend_dir
    tick = 1'b1; dir_valid = 1'b1; dir_in = 2'b00;
    cyc();
    tick = 1'b0; dir_valid = 1'b0;
    chk_w("coinc", 3, 2);
    chk("coinc_dir", 32'(wdir), 2);
    chk("coinc_rej", 32'(wrej), 0);
    do_tick();
    chk_w("coinc_next", 3, 3);
    chk("coinc_next_dir", 32'(wdir), 0);

    // Reversal judged against the step being executed in the same cycle
    tick = 1'b1; dir_valid = 1'b1; dir_in = 2'b01;
    cyc();
    tick = 1'b0; dir_valid = 1'b0;
    chk_w("coinc_rev", 3, 4);
    chk("coinc_rev_rej", 32'(wrej), 1);
    do_tick();
    chk_w("to_3_5", 3, 5);

    // Reset mid-run at (5,5)
    do_dir(2'b10);
    do_tick();
    do_tick();
    chk_w("to_5_5", 5, 5);
    chk("cnt_5_5", 32'(wcnt), 27);
    do_reset();
    chk_w("midrst", 0, 0);
    chk("midrst_run", 32'(wrun), 0);
    chk("midrst_cnt", 32'(wcnt), 0);
    chk("midrst_dir", 32'(wdir), 0);

    // Wall mode: walk to (4,8) then push into the y+1 wall
    do_start();
    do_dir(2'b10);
    for (int i = 0; i < 4; i++) do_tick();
    do_dir(2'b00);
    for (int i = 0; i < 8; i++) do_tick();
    chk("wall_pre_x", 32'(lx), 4);
    chk("wall_pre_y", 32'(ly), 8);
    chk("wall_pre_cnt", 32'(lcnt), 12);
    do_tick();
    chk("wall_x", 32'(lx), 4);
    chk("wall_y", 32'(ly), 8);
    chk("wall_hit", 32'(lhit), 1);
    chk("wall_run", 32'(lrun), 0);
    chk("wall_mov", 32'(lmov), 0);
    chk("wall_cnt", 32'(lcnt), 12);
    chk("wall_dir", 32'(ldir), 0);
    chk_w("wrap_same_step", 4, 0);
    chk("wrap_same_mov", 32'(wmov), 1);

    // DEAD ignores tick, start and direction
    do_tick();
    do_start();
    do_dir(2'b10);
    chk("dead_rej", 32'(lrej), 0);
    do_tick();
    chk("dead_x", 32'(lx), 4);
    chk("dead_y", 32'(ly), 8);
    chk("dead_hit", 32'(lhit), 1);
    chk("dead_run", 32'(lrun), 0);
    chk("dead_dir", 32'(ldir), 0);

    do_reset();
    chk("wrst_x", 32'(lx), 0);
    chk("wrst_y", 32'(ly), 0);
    chk("wrst_hit", 32'(lhit), 0);
    chk("wrst_cnt", 32'(lcnt), 0);

    // Wall at x-1 from column 0
    do_start();
    do_dir(2'b11);
    do_tick();
    chk("wallx_x", 32'(lx), 0);
    chk("wallx_hit", 32'(lhit), 1);
    chk("wallx_dir", 32'(ldir), 3);
    chk_w("wrap_x0", 11, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_head_stepper.md
Name: snake_head_stepper

Overview:
- Parametrised successor to the fixed 12x9 snake coordinate stepper; tracks the snake head position on a GRID_W x GRID_H playfield.
- Adds:
  - buffered direction input with reversal rejection
  - explicit step strobe
  - start/run/dead control FSM
  - selectable wrap or wall mode, with a sticky wall-hit flag
  - saturating move counter
- Sits between the input/direction logic and the body/collision tracker and VGA renderer.

Parameters:
- GRID_W, 12, playfield columns; x range 0..GRID_W-1.
- GRID_H, 9, playfield rows; y range 0..GRID_H-1.
- CW, 4, coordinate width; must satisfy 2^CW >= max(GRID_W, GRID_H).
- WRAP, 1, 1 = wrap at edges; 0 = wall mode, an edge crossing kills the snake.
- START_X, 0, x after reset.
- START_Y, 0, y after reset.
- START_DIR, 2'b00, direction after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: IDLE -> RUN.
- tick  in  1  step strobe; one move per cycle high while in RUN.
- dir_valid  in  1  dir_in is valid this cycle.
- dir_in  in  2  requested direction: 00 y+1, 01 y-1, 10 x+1, 11 x-1.
- xcord  out  CW  head x.
- ycord  out  CW  head y.
- cur_dir  out  2  direction of the last executed step.
- running  out  1  FSM in RUN.
- moved  out  1  one-cycle pulse: coordinates changed this cycle.
- dir_rejected  out  1  one-cycle pulse: a reversal request was dropped.
- wall_hit  out  1  sticky; set on entry to DEAD.
- move_count  out  16  count of executed moves, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). Reset overrides every other input, in any state, including mid-run.
- Reset values:
  - xcord = START_X, ycord = START_Y
  - cur_dir = START_DIR, internal pend_dir = START_DIR
  - state = IDLE
  - running = 0, moved = 0, dir_rejected = 0, wall_hit = 0, move_count = 0
- FSM states: IDLE, RUN, DEAD.
  - IDLE -> RUN on start. tick is ignored in IDLE.
  - RUN -> DEAD only on a wall crossing (WRAP=0).
  - DEAD is exited by reset only.
  - start is ignored in RUN and DEAD.
  - running is registered and goes high the cycle after start is sampled.
- Direction buffering (IDLE and RUN only; ignored in DEAD):
  - A request on dir_valid is a reversal when dir_in[1] == ref[1] and dir_in[0] != ref[0].
  - ref = cur_dir, except when tick is executing a step in the same cycle; then ref = pend_dir (the direction being executed).
  - A non-reversal request loads pend_dir; the last accepted request before a tick wins.
  - A reversal request is dropped and dir_rejected pulses high the next cycle.
  - When dir_valid and tick coincide, the step uses the old pend_dir; the new direction applies from the next tick.
- Step (RUN and tick):
  - Next coordinate is computed from pend_dir, and cur_dir <= pend_dir.
  - Coordinates register on the sampling edge, so they are visible the cycle after tick.
  - moved = 1 in that same cycle. Latency from tick to new coordinates: 1 cycle.
  - Only the axis selected by pend_dir changes; the other coordinate holds.
  - Interior step: +1 or -1 on the selected axis.
- Edge crossing:
  - Edges are y+1 at GRID_H-1, y-1 at 0, x+1 at GRID_W-1, x-1 at 0.
  - WRAP=1: wrap to 0 or to GRID_W-1 / GRID_H-1 as appropriate; counts as a normal move.
  - WRAP=0: coordinates hold, cur_dir updates, state -> DEAD, wall_hit = 1, moved = 0, move_count unchanged.
- move_count increments on each moved pulse and saturates at 16'hFFFF.
- Coordinates never leave the playfield range.

Test Plan:
- WRAP=1, reset, start, dir 00, 9 ticks from (0,0) -> y = 1..8 then 0; x = 0; moved pulses 9 times; move_count = 9.
- WRAP=1, at (0,3) dir_valid 11 then tick -> x = GRID_W-1 = 11, y = 3, cur_dir = 11.
- Running with cur_dir = 10, dir_valid 11 -> dir_rejected pulses; next tick gives x+1. A following dir_valid 00 is accepted; next tick gives y+1.
- tick and dir_valid 00 in the same cycle, pend_dir = 10, at (2,2) -> (3,2). Next tick -> (3,3).
- WRAP=0, at (4,8) dir 00, tick -> stays (4,8), wall_hit = 1, running = 0, moved = 0. Further tick, start and dir inputs cause no change; reset -> (START_X, START_Y), wall_hit = 0.
- tick in IDLE -> no coordinate change. Reset asserted mid-RUN at (5,5) -> next cycle (0,0), IDLE, move_count = 0.
